// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM mux and its far-end demux.
// SEL_W sizes the slot index on both ends of the serial link.
package tdm_pkg;

   localparam int NUM_CH  = 8;
   localparam int SEL_W   = 3;
   localparam int DWELL_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_mux8_slot_timer.sv
// Dwell counter: flags the last cycle of each slot while running.
// slot_end is a decode of the registered count; no backpressure.
module slot_timer
   import tdm_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic restart,
   output logic slot_end
);

   localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

   logic [DWELL_W-1:0] dwell_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_cnt <= '0;
      end else if (restart || !run || slot_end) begin
         dwell_cnt <= '0;
      end else begin
         dwell_cnt <= dwell_cnt + 1'b1;
      end
   end

   assign slot_end = run && (dwell_cnt == LAST);

endmodule

// File: rtl/tdm_mux8.sv
// Snapshots an 8-bit word and serialises it one bit per slot with its slot index.
// Slot 0 appears the cycle after en is sampled; frames run back-to-back while en holds.
module tdm_mux8
   import tdm_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [NUM_CH-1:0] data_in,
   output logic             data_out,
   output logic [SEL_W-1:0] sel,
   output logic             slot_valid,
   output logic             frame_start,
   output logic             busy
);

   state_t            state;
   logic [NUM_CH-1:0] snap;
   logic              run;
   logic              restart;
   logic              slot_end;
   logic [SEL_W-1:0]  sel_nxt;

   assign run     = (state == ST_RUN);
   assign restart = (state == ST_IDLE) && en;
   assign sel_nxt = sel + 1'b1;

   slot_timer #(
      .DWELL (DWELL)
   ) u_slot_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .restart  (restart),
      .slot_end (slot_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         snap        <= '0;
         sel         <= '0;
         data_out    <= 1'b0;
         slot_valid  <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en) begin
                  state       <= ST_RUN;
                  snap        <= data_in;
                  sel         <= '0;
                  data_out    <= data_in[0];
                  slot_valid  <= 1'b1;
                  frame_start <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            ST_RUN: begin
               if (slot_end) begin
                  if (sel == SEL_W'(NUM_CH - 1)) begin
                     // Frame boundary: en decides between an immediate next frame and IDLE.
                     if (en) begin
                        snap        <= data_in;
                        sel         <= '0;
                        data_out    <= data_in[0];
                        frame_start <= 1'b1;
                     end else begin
                        state      <= ST_IDLE;
                        sel        <= '0;
                        data_out   <= 1'b0;
                        slot_valid <= 1'b0;
                        busy       <= 1'b0;
                     end
                  end else begin
                     sel      <= sel_nxt;
                     data_out <= snap[sel_nxt];
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
